// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// drives the IF/ID register. Optional misaligned-redirect trap: IF_MISALIGN_FAULT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4
`ifdef IF_MISALIGN_FAULT_EN
  ,
  output logic        if_id_fault
`endif
);

`ifdef IF_MISALIGN_FAULT_EN
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        kill;
  logic [31:0] hold_insn;
  logic [31:0] hold_pc;
  logic [31:0] redirect_tgt;
  logic        if_id_free;
  logic        load_en;
  logic        load_fault;
  logic [31:0] load_insn;
  logic [31:0] load_pc;

`ifdef IF_MISALIGN_FAULT_EN
  logic fault_pending;
  logic redirect_bad;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
`endif

  assign imem_req_valid = !rst && (state == S_FETCH) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign if_id_free     = !if_id_valid || !id_stall;

  // Source selection for a non-flush IF/ID load; the priority chain lives in the register block.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_en    = 1'b0;
    load_fault = 1'b0;
    load_insn  = imem_resp_data;
    load_pc    = inflight_pc;
    case (state)
      S_WAIT:  load_en = imem_resp_valid && !kill && !redirect_valid && if_id_free;
      S_HOLD: begin
        load_en   = !id_stall;
        load_insn = hold_insn;
        load_pc   = hold_pc;
      end
`ifdef IF_MISALIGN_FAULT_EN
      S_FAULT: begin
        load_en    = fault_pending;
        load_fault = 1'b1;
        load_insn  = NOP_INSN;
        load_pc    = pc;
      end
`endif
      default: load_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      inflight_pc <= 32'h0;
      kill        <= 1'b0;
      hold_insn   <= 32'h0;
      hold_pc     <= 32'h0;
`ifdef IF_MISALIGN_FAULT_EN
      fault_pending <= 1'b0;
`endif
    end else begin
      if (redirect_valid && state != S_BOOT) begin
        pc <= redirect_tgt;
`ifdef IF_MISALIGN_FAULT_EN
        fault_pending <= redirect_bad;
        if (redirect_bad) state <= S_FAULT;
        else              state <= S_FETCH;
`else
        state <= S_FETCH;
`endif
      end
      case (state)
        S_BOOT: state <= S_FETCH;
        S_FETCH: begin
          if (!redirect_valid && imem_req_ready) begin
            inflight_pc <= pc;
            pc          <= pc + 32'd4;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            kill <= 1'b0;
            if (!kill && !redirect_valid) begin
              if (if_id_free) begin
                state <= S_FETCH;
              end else begin
                hold_insn <= imem_resp_data;
                hold_pc   <= inflight_pc;
                state     <= S_HOLD;
              end
            end else if (!redirect_valid) begin
              state <= S_FETCH;
            end
          end else if (redirect_valid) begin
            // The request is still outstanding: stay and swallow its response.
            kill <= 1'b1;
`ifdef IF_MISALIGN_FAULT_EN
            if (!redirect_bad) state <= S_WAIT;
`else
            state <= S_WAIT;
`endif
          end
        end
        S_HOLD: begin
          if (!redirect_valid && !id_stall) state <= S_FETCH;
        end
`ifdef IF_MISALIGN_FAULT_EN
        S_FAULT: begin
          if (imem_resp_valid) kill <= 1'b0;
          if (!redirect_valid && !(id_stall && if_id_valid)) fault_pending <= 1'b0;
        end
`endif
        default: state <= S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP_INSN;
      if_id_pc          <= 32'h0;
      if_id_pc_plus4    <= 32'h4;
`ifdef IF_MISALIGN_FAULT_EN
      if_id_fault       <= 1'b0;
`endif
    end else if (redirect_valid) begin
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP_INSN;
`ifdef IF_MISALIGN_FAULT_EN
      if_id_fault       <= 1'b0;
`endif
    end else if (id_stall && if_id_valid) begin
      if_id_valid <= 1'b1;
    end else if (load_en) begin
      if_id_valid       <= 1'b1;
      if_id_instruction <= load_insn;
      if_id_pc          <= load_pc;
      if_id_pc_plus4    <= load_pc + 32'd4;
`ifdef IF_MISALIGN_FAULT_EN
      if_id_fault       <= load_fault;
`endif
    end else begin
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP_INSN;
`ifdef IF_MISALIGN_FAULT_EN
      if_id_fault       <= 1'b0;
`endif
    end
  end

`ifndef IF_MISALIGN_FAULT_EN
  logic unused_load_fault;
  assign unused_load_fault = load_fault;
`endif

endmodule
